// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the feature-map stream reader.
// Defaults match the 2x2 max-pool output buffer (32ch x 16x16, 4-bit).
package fmap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_UP,
    ISSUE,
    HOLD,
    DRAIN
  } state_e;

  localparam int DEF_CHANNELS = 32;
  localparam int DEF_HEIGHT   = 16;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DATA_W   = 4;

  function automatic int fmap_total(input int channels, input int height, input int width);
    return channels * height * width;
  endfunction

  // A dimension of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_skid_fifo.sv
// Two-entry valid/ready FIFO carrying an activation and its last flag.
// Entry 0 is always the head, so the output holds still while stalled.
module fmap_skid_fifo
  import fmap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              full,
  output logic              empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [1:0]        count_q, count_d;
  logic              pop;

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = count_q;
    pop     = (count_q != 2'd0) && m_ready;
    case ({push_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = push_data;
          last0_d = push_last;
        end else begin
          data1_d = push_data;
          last1_d = push_last;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while the new entry arrives; occupancy is unchanged.
        if (count_q == 2'd1) begin
          data0_d = push_data;
          last0_d = push_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = push_data;
          last1_d = push_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign m_valid = !empty;
  assign m_data  = data0_q;
  assign m_last  = last0_q;

endmodule

// File: rtl/fmap_stream_reader.sv
// Starts the upstream layer, then reads its feature map element by element
// (channel/row/column order) and emits it as a valid/ready stream with last.
module fmap_stream_reader
  import fmap_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              up_start,
  input  logic              up_done,
  output logic [ADDR_W-1:0] up_read_addr,
  input  logic [DATA_W-1:0] up_read_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CH_W  = cnt_width(CHANNELS);
  localparam int ROW_W = cnt_width(HEIGHT);
  localparam int COL_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  elem_q, elem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         hold_q, hold_d;
  logic               up_start_q, up_start_d;
  logic               push_valid;
  logic               fifo_full, fifo_empty;
  logic               is_last;

  assign is_last = (ch_q == CH_W'(CHANNELS - 1)) && (row_q == ROW_W'(HEIGHT - 1)) &&
                   (col_q == COL_W'(WIDTH - 1));

  // elem_q tracks ch*H*W + row*W + col incrementally, so no multiplier is needed.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    row_d      = row_q;
    col_d      = col_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    up_start_d = 1'b0;
    push_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          up_start_d = 1'b1;
          state_d    = WAIT_UP;
        end
      end
      WAIT_UP: begin
        if (up_done) begin
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          elem_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!fifo_full) begin
          addr_d  = elem_q;
          hold_d  = 2'(READ_LATENCY);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == 2'd0) begin
          push_valid = 1'b1;
          elem_d     = is_last ? '0 : elem_q + ADDR_W'(1);
          if (col_q == COL_W'(WIDTH - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(HEIGHT - 1)) begin
              row_d = '0;
              ch_d  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
          state_d = is_last ? DRAIN : ISSUE;
        end else begin
          hold_d = hold_q - 2'd1;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      elem_q     <= '0;
      addr_q     <= '0;
      hold_q     <= 2'd0;
      up_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      row_q      <= row_d;
      col_q      <= col_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      up_start_q <= up_start_d;
    end
  end

  fmap_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push_valid(push_valid),
    .push_data (up_read_data),
    .push_last (is_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Done fires in the cycle right after the final beat leaves the FIFO.
  assign done         = (state_q == DRAIN) && fifo_empty;
  assign busy         = (state_q != IDLE);
  assign up_start     = up_start_q;
  assign up_read_addr = addr_q;

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: a full-size instance driven through full,
// stalled and interrupted passes, and a tiny READ_LATENCY=2 instance.
module tb_fmap_stream_reader;
  import fmap_pkg::*;

  localparam int TOTAL_A = fmap_total(DEF_CHANNELS, DEF_HEIGHT, DEF_WIDTH);

  typedef struct {
    logic [3:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic        m_ready;
    logic        exp_valid;
    logic        exp_last;
    logic [3:0]  exp_data;
    logic [31:0] exp_addr;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  logic clk;
  logic resetn;

  logic        start_a, busy_a, done_a, up_start_a, up_done_a;
  logic [31:0] up_read_addr_a;
  logic [3:0]  up_read_data_a, stage1_a;
  logic        m_valid_a, m_ready_a, m_last_a;
  logic [3:0]  m_data_a;

  logic        start_b, busy_b, done_b, up_start_b, up_done_b;
  logic [31:0] up_read_addr_b;
  logic [3:0]  stage1_b, stage2_b;
  logic        m_valid_b, m_ready_b, m_last_b;
  logic [3:0]  m_data_b;

  int checks = 0;
  int errors = 0;
  beat_t sb[$];
  beat_t exp_b;
  int beats_a = 0;
  int done_cnt_a = 0;
  int up_start_cnt_a = 0;
  int ready_mode = 0;
  logic last_hs_prev = 1'b0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [31:0] addr_prev = '0;
  int since_change = 100;
  vec_t tbl[11];

  fmap_stream_reader dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
    .up_start(up_start_a), .up_done(up_done_a), .up_read_addr(up_read_addr_a),
    .up_read_data(up_read_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_last(m_last_a)
  );

  fmap_stream_reader #(
    .CHANNELS(1), .HEIGHT(1), .WIDTH(2), .DATA_W(4), .ADDR_W(32), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
    .up_start(up_start_b), .up_done(up_done_b), .up_read_addr(up_read_addr_b),
    .up_read_data(stage2_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_last(m_last_b)
  );

  function automatic logic [3:0] model_data(input int i);
    int p;
    p = i * 7;
    return p[3:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream BRAM models: one output register stage for A, two for B.
  always @(posedge clk) begin
    stage1_a <= model_data(int'(up_read_addr_a));
    stage1_b <= model_data(int'(up_read_addr_b)) + 4'd3;
    stage2_b <= stage1_b;
  end
  assign up_read_data_a = stage1_a;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard, stream-stability, done-timing, address-hold and FIFO-push checks on A.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall   = 1'b0;
      last_hs_prev = 1'b0;
      since_change = 100;
      addr_prev    = up_read_addr_a;
    end else begin
      if (up_start_a) up_start_cnt_a++;
      if (done_a || last_hs_prev) checkOutput("done_after_last", 32'(done_a), 32'(last_hs_prev));
      if (done_a) done_cnt_a++;
      last_hs_prev = 1'b0;
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(m_valid_a), 32'd1);
        checkOutput("stall_data", 32'(m_data_a), 32'(prev_data));
        checkOutput("stall_last", 32'(m_last_a), 32'(prev_last));
      end
      if (up_read_addr_a != addr_prev) begin
        checkOutput("addr_hold_window", 32'(since_change >= 3), 32'd1);
        since_change = 1;
        addr_prev    = up_read_addr_a;
      end else begin
        since_change++;
      end
      if (dut_a.u_fifo.push_valid) checkOutput("push_into_full", 32'(dut_a.u_fifo.full), 32'd0);
      if (m_valid_a && m_ready_a) begin
        beats_a++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_b = sb.pop_front();
          checkOutput("beat_data", 32'(m_data_a), 32'(exp_b.data));
          checkOutput("beat_last", 32'(m_last_a), 32'(exp_b.last));
        end
        last_hs_prev = m_last_a;
      end
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
      prev_last  = m_last_a;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready_a = 1'b1;
        1:       m_ready_a = ($urandom_range(0, 99) < 30);
        default: m_ready_a = 1'b0;
      endcase
    end
  end

  task automatic applyStimulus();
    sb.delete();
    for (int i = 0; i < TOTAL_A; i++) begin
      beat_t b;
      b.data = model_data(i);
      b.last = (i == TOTAL_A - 1);
      sb.push_back(b);
    end
    beats_a = 0;
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  // Answers up_start after 'delay' cycles, pulsing an extra start at 'extra_at'.
  task automatic upstreamHandshake(input int delay, input int extra_at);
    logic [31:0] addr0;
    int waited;
    waited = 0;
    while (!up_start_a && waited < 20) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("up_start_seen", 32'(up_start_a), 32'd1);
    addr0 = up_read_addr_a;
    for (int c = 1; c <= delay; c++) begin
      @(posedge clk);
      #1 start_a = (c == extra_at);
      checkOutput("wait_up_no_valid", 32'(m_valid_a), 32'd0);
      checkOutput("wait_up_addr_still", up_read_addr_a, addr0);
    end
    start_a   = 1'b0;
    up_done_a = 1'b1;
    @(posedge clk);
    #1 up_done_a = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_up_start", 32'(up_start_a), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid_a), 32'd0);
    checkOutput("rst_m_last", 32'(m_last_a), 32'd0);
    checkOutput("rst_m_data", 32'(m_data_a), 32'd0);
    checkOutput("rst_addr", up_read_addr_a, 32'd0);
  endtask

  initial begin
    int budget;
    // Per-edge expectations for B after up_done: {ready, valid, last, data, addr, done, busy}.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd3,  32'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd10, 32'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  32'd1, 1'b0, 1'b0};

    resetn = 1'b0;
    start_a = 1'b0; up_done_a = 1'b0; m_ready_a = 1'b1;
    start_b = 1'b0; up_done_b = 1'b0; m_ready_b = 1'b1;
    #23;
    checkResetState();
    @(negedge clk) resetn = 1'b1;

    $display("[TB] small instance, READ_LATENCY=2");
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    checkOutput("b_up_start", 32'(up_start_b), 32'd1);
    @(posedge clk);
    #1 up_done_b = 1'b1;
    @(posedge clk);
    #1 up_done_b = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        m_ready_b = tbl[k].m_ready;
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("b_valid_%0d", k), 32'(m_valid_b), 32'(tbl[k].exp_valid));
      checkOutput($sformatf("b_addr_%0d", k), up_read_addr_b, tbl[k].exp_addr);
      checkOutput($sformatf("b_done_%0d", k), 32'(done_b), 32'(tbl[k].exp_done));
      checkOutput($sformatf("b_busy_%0d", k), 32'(busy_b), 32'(tbl[k].exp_busy));
      if (tbl[k].exp_valid) begin
        checkOutput($sformatf("b_data_%0d", k), 32'(m_data_b), 32'(tbl[k].exp_data));
        checkOutput($sformatf("b_last_%0d", k), 32'(m_last_b), 32'(tbl[k].exp_last));
      end
    end

    $display("[TB] full pass at full m_ready");
    ready_mode = 0;
    applyStimulus();
    upstreamHandshake(5, 0);
    budget = 0;
    while (done_cnt_a < 1 && budget < 30000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("pass1_done_in_time", 32'(done_cnt_a), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("pass1_beats", 32'(beats_a), 32'(TOTAL_A));
    checkOutput("pass1_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("pass1_busy_low", 32'(busy_a), 32'd0);
    checkOutput("pass1_up_starts", 32'(up_start_cnt_a), 32'd1);

    $display("[TB] random m_ready, late up_done, reset at beat 1000");
    ready_mode = 1;
    applyStimulus();
    upstreamHandshake(200, 50);
    checkOutput("pass2_one_up_start", 32'(up_start_cnt_a), 32'd2);
    budget = 0;
    while (beats_a < 1000 && budget < 10000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("pass2_reached_1000", 32'(beats_a >= 1000), 32'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(m_valid_a), 32'd0);
    checkOutput("async_rst_busy", 32'(busy_a), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 checkResetState();
    @(negedge clk) resetn = 1'b1;

    $display("[TB] restart with downstream stalled");
    ready_mode = 2;
    m_ready_a  = 1'b0;
    applyStimulus();
    upstreamHandshake(3, 0);
    budget = 0;
    while (!m_valid_a && budget < 50) begin
      @(posedge clk);
      #1 budget++;
    end
    checkOutput("pass3_first_valid", 32'(m_valid_a), 32'd1);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("stall_head_data", 32'(m_data_a), 32'd0);
    checkOutput("stall_head_last", 32'(m_last_a), 32'd0);
    checkOutput("stall_addr_parked", up_read_addr_a, 32'd1);
    checkOutput("stall_fifo_full", 32'(dut_a.u_fifo.full), 32'd1);
    ready_mode = 0;
    budget = 0;
    while (beats_a < 300 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("pass3_beats", 32'(beats_a >= 300), 32'd1);
    checkOutput("pass3_no_done", 32'(done_cnt_a), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
- Consumer end of a layer's `read_addr`/`read_data` output interface, e.g. the 2x2 max-pool output buffer (32ch x 16x16, 4-bit activations).
- Pulses the upstream layer's start and waits for its done.
- Then sweeps every activation in channel-major, row-major order and presents it as a valid/ready stream with a last flag to the next layer or a DMA engine.
- Hides upstream BRAM read latency and the address-hold requirement of the upstream nibble-select mux.

Parameters:
- CHANNELS, 32, number of feature-map channels
- HEIGHT, 16, rows per channel
- WIDTH, 16, columns per channel
- DATA_W, 4, activation width in bits
- ADDR_W, 32, upstream address width
- READ_LATENCY, 1, upstream BRAM output register stages (1 or 2)

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to run one full pass
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last beat is accepted
- up_start  output  1  one-cycle start pulse to the upstream layer
- up_done  input  1  upstream completion pulse
- up_read_addr  output  ADDR_W  upstream element address, registered
- up_read_data  input  DATA_W  upstream element data
- m_valid  output  1  stream beat valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_W  activation value
- m_last  output  1  high on the final beat (element CHANNELS*HEIGHT*WIDTH-1)

Behaviour:
- Reset (async, resetn low): state IDLE; busy, done, up_start, m_valid, m_last = 0; m_data = 0; up_read_addr = 0; FIFO emptied; counters = 0. Reset mid-pass abandons the pass; no done is produced.
- Element address:
  - addr = ch*HEIGHT*WIDTH + row*WIDTH + col.
  - Counted by ch/row/col counters, not by a multiplier.
  - col wraps at WIDTH-1 to 0 and increments row; row wraps at HEIGHT-1 to 0 and increments ch.
- Upstream read contract:
  - up_read_data is valid only once up_read_addr has been stable for READ_LATENCY+1 rising edges.
  - up_read_addr must not change while a read is outstanding.
- FSM:
  - IDLE: start -> assert up_start for 1 cycle, busy=1, go to WAIT_UP. Start while busy is ignored.
  - WAIT_UP: up_done -> reset counters, go to ISSUE. up_read_addr stays unchanged while waiting.
  - ISSUE: only if the FIFO has a free slot. Drive up_read_addr = current element, load hold counter = READ_LATENCY, go to HOLD. Otherwise stay in ISSUE.
  - HOLD: decrement the hold counter each cycle. When it reaches 0, push {up_read_data, is_last} into the FIFO (the sample edge is the (READ_LATENCY+1)th edge after the address changed). Then advance counters: if is_last go to DRAIN, else go to ISSUE.
  - DRAIN: wait until the FIFO is empty and the last beat is accepted. Then assert done for 1 cycle, busy=0, go to IDLE.
- Throughput: one element per READ_LATENCY+2 cycles at full m_ready.
- Output FIFO:
  - 2 entries; m_valid = not empty; m_data/m_last come from the head.
  - A push into a full FIFO is impossible by construction; the bench asserts on it.
  - Push and pop in the same cycle are both honoured.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_last hold stable.
- m_last is asserted on exactly one beat per pass.
- A new start during the done cycle is ignored; start is accepted from the next cycle.

Decomposition:
- Shared package fmap_pkg holds:
  - the state enum (IDLE, WAIT_UP, ISSUE, HOLD, DRAIN)
  - default CH/H/W/DATA_W constants matching the max-pool stage
  - the TOTAL = CHANNELS*HEIGHT*WIDTH localparam function
- One sub-module: fmap_skid_fifo, a 2-entry valid/ready FIFO with data+last payload and async active-low reset.

Test Plan:
- Default params, upstream model returns (addr*7)[3:0] with READ_LATENCY=1 timing, m_ready=1 -> exactly 8192 beats with m_data=(i*7)[3:0]; m_last only on beat 8191; done one cycle after that handshake; busy low afterward.
- Random m_ready (30% high) -> identical sequence, no loss or duplicates; m_data stable while stalled; up_read_addr never changes within a hold window (assertion).
- up_done delayed 200 cycles after up_start; a second start pulse at cycle 50 -> exactly one up_start; no m_valid and no up_read_addr change before up_done.
- resetn dropped asynchronously mid-cycle at beat 1000 -> m_valid/busy go 0 immediately without a clock; after release, a new start streams from addr 0, value 0.
- READ_LATENCY=2, CHANNELS=1, HEIGHT=1, WIDTH=2 -> address held 3 edges per element; two beats, m_last on the second; done pulse once.
- m_ready held 0 for 50 cycles after the first beat -> FIFO fills to 2; the reader stalls in ISSUE with no overwrite; after release, order is preserved.
